// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store AXI-lite master.
// Contents: access-size enum, FSM state enum, AXI response codes, size_to_bytes().
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_A    = 3'd1,
        RD_D    = 3'd2,
        WR_AW_W = 3'd3,
        WR_B    = 3'd4,
        RESP    = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
    function automatic logic [3:0] size_to_bytes(input lsu_size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Byte-lane steering between the pipeline and a DATA_W-wide bus.
// Store side: st_data shifted to its byte offset, plus the matching strobe.
// Load side:  ld_lane shifted down by its offset, masked to size, sign/zero-extended.
// Ports: st_off/st_size/st_data -> st_lane/st_strb;
//        ld_off/ld_size/ld_unsigned/ld_lane -> ld_data.
module mem_lsu_lane_align
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] st_off,
    input  lsu_size_e                   st_size,
    input  logic [DATA_W-1:0]           st_data,
    output logic [DATA_W-1:0]           st_lane,
    output logic [DATA_W/8-1:0]         st_strb,
    input  logic [$clog2(DATA_W/8)-1:0] ld_off,
    input  lsu_size_e                   ld_size,
    input  logic                        ld_unsigned,
    input  logic [DATA_W-1:0]           ld_lane,
    output logic [DATA_W-1:0]           ld_data
);
    localparam int unsigned STRB_W = DATA_W / 8;

    // Store: data moves up by 8*offset; strobe covers [offset, offset+bytes).
    always_comb begin
        int unsigned off;
        int unsigned nbytes;
        off     = 32'(st_off);
        nbytes  = 32'(size_to_bytes(st_size));
        st_lane = st_data << {st_off, 3'b000};
        st_strb = '0;
        for (int i = 0; i < STRB_W; i++) begin
            st_strb[i] = (i >= off) && (i < off + nbytes);
        end
    end

    // Load: bring the addressed bytes to bit 0, then extend from the top loaded bit.
    always_comb begin
        logic [DATA_W-1:0] shifted;
        int unsigned       nbits;
        logic              sign;
        shifted = ld_lane >> {ld_off, 3'b000};
        nbits   = 8 * 32'(size_to_bytes(ld_size));
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) begin
                sign = shifted[i];
            end
        end
        sign    = sign & ~ld_unsigned;
        ld_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

endmodule

// File: rtl/mem_lsu_axi_master.sv
// MEM-stage load/store AXI-lite master: one request at a time, lane alignment,
// load extension, misalignment / bus-error reporting, concurrent AW/W issue.
// Optional watchdog enabled by defining MEM_LSU_TIMEOUT_EN (TIMEOUT_CYC cycles
// per bus state before the access is abandoned with an error).
// Ports: clk, rst (async, active high);
//        pipeline side req_* / resp_*;
//        AXI-lite AR/R/AW/W/B channels toward the arbiter/xbar.
module mem_lsu_axi_master
    import mem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);

    lsu_state_e        state;
    logic [OFF_W-1:0]  off_lat;
    lsu_size_e         size_lat;
    logic              uns_lat;
    logic              aw_done;
    logic              w_done;

    lsu_size_e         req_sz;
    logic              req_bad;
    logic [DATA_W-1:0] st_lane;
    logic [STRB_W-1:0] st_strb;
    logic [DATA_W-1:0] ld_ext;
    logic              tmo_hit;

    assign req_sz = lsu_size_e'(req_size);

    // Address not a multiple of the access size, or a double on a 32-bit bus.
    assign req_bad = ((req_sz == DOUBLE) && (DATA_W == 32)) ||
                     ((req_addr[2:0] & 3'(size_to_bytes(req_sz) - 4'd1)) != 3'd0);

    mem_lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_off      (req_addr[OFF_W-1:0]),
        .st_size     (req_sz),
        .st_data     (req_wdata),
        .st_lane     (st_lane),
        .st_strb     (st_strb),
        .ld_off      (off_lat),
        .ld_size     (size_lat),
        .ld_unsigned (uns_lat),
        .ld_lane     (rdata),
        .ld_data     (ld_ext)
    );

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             busy;
    logic             leave;

    // leave: the current bus state completes this cycle (counter restarts).
    always_comb begin
        busy  = (state == RD_A) || (state == RD_D) || (state == WR_AW_W) || (state == WR_B);
        leave = 1'b0;
        case (state)
            RD_A:    leave = arready;
            RD_D:    leave = rvalid;
            WR_AW_W: leave = (aw_done || awready) && (w_done || wready);
            WR_B:    leave = bvalid;
            default: leave = 1'b0;
        endcase
        tmo_hit = busy && !leave && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Cycles spent in the current bus state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!busy || leave || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_tmo_cyc;

    assign tmo_hit        = 1'b0;
    assign unused_tmo_cyc = 32'(TIMEOUT_CYC);
`endif

    // Control FSM; every pipeline and AXI output is a register written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off_lat    <= '0;
            size_lat   <= BYTE;
            uns_lat    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_lat   <= req_addr[OFF_W-1:0];
                        size_lat  <= req_sz;
                        uns_lat   <= req_unsigned;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we) begin
                            state   <= WR_AW_W;
                            awaddr  <= req_addr;
                            awvalid <= 1'b1;
                            wdata   <= st_lane;
                            wstrb   <= st_strb;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= RD_A;
                            araddr  <= req_addr;
                            arvalid <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_rdata <= ld_ext;
                        resp_err   <= (rresp != AXI_RESP_OKAY);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WR_AW_W: begin
                    // AW and W complete independently; leave once both are done.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || awready) && (w_done || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= (bresp != AXI_RESP_OKAY);
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Watchdog expiry abandons the bus access; overrides the case above.
            if (tmo_hit) begin
                arvalid    <= 1'b0;
                rready     <= 1'b0;
                awvalid    <= 1'b0;
                wvalid     <= 1'b0;
                bready     <= 1'b0;
                resp_rdata <= '0;
                resp_err   <= 1'b1;
                resp_valid <= 1'b1;
                state      <= RESP;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu_axi_master.sv
`timescale 1ns/1ps
module tb_mem_lsu_axi_master;
    import mem_lsu_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [1:0]    req_size;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] araddr, awaddr;
    logic          arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0] rdata, wdata;
    logic [1:0]    rresp, bresp;
    logic [3:0]    wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_lsu_axi_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic [31:0] rdata, araddr, awaddr, wdata;
        logic [3:0]  wstrb;
        logic        err;
        int          lat, b_hs;
        bit          ar_seen, aw_seen, unstable, hang;
        bit          start_ready, resp_req_ready, post_valid, post_req_ready;
    } obs_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for a 32-bit bus, from the access rules directly.
    function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rd, input int size, input bit uns,
                                  input logic [1:0] rsp, output bit e_bad, output bit e_err,
                                  output logic [31:0] e_rdata, output logic [31:0] e_wdata,
                                  output logic [3:0] e_strb);
        int nb, off;
        longint unsigned v, mask;
        nb      = 1 << size;
        e_bad   = (size == 3) || ((addr % nb) != 0);
        off     = int'(addr % 4);
        e_wdata = 32'(64'(wd) << (8 * off));
        e_strb  = 4'(((1 << nb) - 1) << off);
        mask    = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * nb)) - 64'd1;
        v       = (64'(rd) >> (8 * off)) & mask;
        if (!uns && (((v >> (8 * nb - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
        e_rdata = (we || e_bad) ? 32'd0 : 32'(v);
        e_err   = e_bad || (rsp != AXI_RESP_OKAY);
    endfunction

    // Issues one request at a negedge, plays the AXI slave with the given waits,
    // then consumes the response after 'hold' stalled cycles.
    task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size, input bit uns, input logic [31:0] srdata,
                           input logic [1:0] srsp, input int ar_d, input int r_d, input int aw_d,
                           input int w_d, input int b_d, input int hold, output obs_t o);
        bit ar_v, r_v, aw_v, w_v, b_v, ar_done, r_done, aw_done, w_done;
        int ar_c, r_c, aw_c, w_c, b_c;
        o = '{default: 0};
        {ar_v, r_v, aw_v, w_v, b_v, ar_done, r_done, aw_done, w_done} = '0;
        {ar_c, r_c, aw_c, w_c, b_c} = '0;
        o.hang = 1'b1;
        o.start_ready = req_ready;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (ar_v && arready) ar_done = 1'b1;
            if (r_v && rvalid) r_done = 1'b1;
            if (aw_v && awready) aw_done = 1'b1;
            if (w_v && wready) w_done = 1'b1;
            if (b_v && bvalid) o.b_hs++;
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            if (resp_valid === 1'b1) begin
                o.lat  = cyc;
                o.hang = 1'b0;
                break;
            end
            ar_v = arvalid; r_v = rready; aw_v = awvalid; w_v = wvalid; b_v = bready;
            if (arvalid) begin
                if (!o.ar_seen) o.araddr = araddr;
                else if (araddr !== o.araddr) o.unstable = 1'b1;
                o.ar_seen = 1'b1;
                if (ar_c >= ar_d) arready = 1'b1;
                ar_c++;
            end
            if (ar_done && !r_done) begin
                if (r_c >= r_d) begin rvalid = 1'b1; rdata = srdata; rresp = srsp; end
                r_c++;
            end
            if (awvalid) begin
                if (!o.aw_seen) o.awaddr = awaddr;
                o.aw_seen = 1'b1;
                if (aw_c >= aw_d) awready = 1'b1;
                aw_c++;
            end
            if (wvalid) begin
                o.wdata = wdata; o.wstrb = wstrb;
                if (w_c >= w_d) wready = 1'b1;
                w_c++;
            end
            if (aw_done && w_done) begin
                if (b_c >= b_d) begin bvalid = 1'b1; bresp = srsp; end
                b_c++;
            end
        end
        if (!o.hang) begin
            o.rdata = resp_rdata; o.err = resp_err; o.resp_req_ready = req_ready;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (resp_valid !== 1'b1 || resp_rdata !== o.rdata || resp_err !== o.err) o.unstable = 1'b1;
            end
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            o.post_valid = resp_valid; o.post_req_ready = req_ready;
        end
    endtask

    // Common per-transaction comparisons against model-derived expectations.
    task automatic check_txn(input string tag, input obs_t o, input bit we, input logic [31:0] addr,
                             input bit e_bad, input bit e_err, input logic [31:0] e_rdata,
                             input logic [31:0] e_wdata, input logic [3:0] e_strb, input int e_lat);
        bit rd_bus, wr_bus;
        rd_bus = !we && !e_bad;
        wr_bus = we && !e_bad;
        check({tag, "_hang"}, o.hang, 0);
        check({tag, "_start_ready"}, o.start_ready, 1);
        check({tag, "_err"}, o.err, e_err);
        check({tag, "_rdata"}, o.rdata, e_rdata);
        check({tag, "_lat"}, o.lat, e_lat);
        check({tag, "_ar_seen"}, o.ar_seen, rd_bus);
        check({tag, "_araddr"}, o.araddr, rd_bus ? addr : 32'd0);
        check({tag, "_aw_seen"}, o.aw_seen, wr_bus);
        check({tag, "_awaddr"}, o.awaddr, wr_bus ? addr : 32'd0);
        check({tag, "_wdata"}, o.wdata, wr_bus ? e_wdata : 32'd0);
        check({tag, "_wstrb"}, o.wstrb, wr_bus ? e_strb : 4'd0);
        check({tag, "_b_hs"}, o.b_hs, wr_bus ? 1 : 0);
        check({tag, "_stable"}, o.unstable, 0);
        check({tag, "_busy_ready"}, o.resp_req_ready, 0);
        check({tag, "_post_valid"}, o.post_valid, 0);
        check({tag, "_post_ready"}, o.post_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        obs_t o;
        bit e_bad, e_err, we, uns;
        logic [31:0] e_rdata, e_wdata, addr, wd, rd;
        logic [3:0] e_strb;
        logic [1:0] rsp;
        int sz, s, ard, rdd, awd, wdd, bd, e_lat;

        rst = 1'b1;
        {req_valid, req_we, req_unsigned, resp_ready} = '0;
        req_addr = '0; req_wdata = '0; req_size = '0;
        {arready, rvalid, awready, wready, bvalid} = '0;
        rdata = '0; rresp = '0; bresp = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 0);
        check("rst_rdata", resp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Signed byte load from the top lane, zero-wait slave.
        run_txn(0, 32'h8000_0003, 0, 2'd0, 0, 32'h80FF_1234, AXI_RESP_OKAY, 0, 0, 0, 0, 0, 1, o);
        check("lb_rdata", o.rdata, 32'hFFFF_FF80);
        check("lb_err", o.err, 0);
        check("lb_lat", o.lat, 3);
        check("lb_araddr", o.araddr, 32'h8000_0003);

        // Half store to upper lanes; AW accepted two cycles before W.
        run_txn(1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 0, 0, AXI_RESP_OKAY, 0, 0, 0, 2, 0, 2, o);
        check("sh_wdata", o.wdata, 32'hBEEF_0000);
        check("sh_wstrb", o.wstrb, 4'b1100);
        check("sh_b_hs", o.b_hs, 1);
        check("sh_err", o.err, 0);
        check("sh_lat", o.lat, 5);

        // Misaligned word load: error on the next cycle, no AR.
        run_txn(0, 32'h8000_0001, 0, 2'd2, 0, 32'h1111_1111, AXI_RESP_OKAY, 0, 0, 0, 0, 0, 0, o);
        check("mis_err", o.err, 1);
        check("mis_lat", o.lat, 1);
        check("mis_ar_seen", o.ar_seen, 0);
        check("mis_rdata", o.rdata, 0);

        // Bus errors on read and write responses.
        run_txn(0, 32'h8000_0004, 0, 2'd2, 0, 32'h1234_5678, AXI_RESP_SLVERR, 0, 1, 0, 0, 0, 0, o);
        check("rerr_err", o.err, 1);
        check("rerr_rdata", o.rdata, 32'h1234_5678);
        run_txn(1, 32'h8000_0008, 32'hCAFE_F00D, 2'd2, 0, 0, AXI_RESP_DECERR, 0, 0, 1, 0, 1, 0, o);
        check("berr_err", o.err, 1);
        check("berr_wstrb", o.wstrb, 4'b1111);

        // Asynchronous reset while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_arvalid", arvalid, 1);
        arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arready = 1'b0;
        check("mid_rready", rready, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_outputs", {arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err}, 0);
        check("arst_req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(0, 32'h8000_0002, 0, 2'd1, 1, 32'hABCD_0000, AXI_RESP_OKAY, 0, 0, 0, 0, 0, 0, o);
        check("post_rst_rdata", o.rdata, 32'h0000_ABCD);
        check("post_rst_err", o.err, 0);
        check("post_rst_lat", o.lat, 3);

`ifdef MEM_LSU_TIMEOUT_EN
        // AR never accepted: watchdog ends the access after TMO cycles in RD_A.
        run_txn(0, 32'h8000_0020, 0, 2'd2, 0, 0, AXI_RESP_OKAY, 1000, 0, 0, 0, 0, 0, o);
        check("tmo_err", o.err, 1);
        check("tmo_lat", o.lat, TMO + 1);
        check("tmo_rdata", o.rdata, 0);
        check("tmo_arvalid_low", arvalid, 0);
`endif

        // Randomised mix of loads/stores, sizes, alignment, responses and waits.
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, 9);
            sz  = (s < 3) ? 0 : (s < 6) ? 1 : (s < 9) ? 2 : 3;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'((1 << sz) - 1);
            wd  = $urandom;
            rd  = $urandom;
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : AXI_RESP_OKAY;
            ard = $urandom_range(0, 2); rdd = $urandom_range(0, 2);
            awd = $urandom_range(0, 2); wdd = $urandom_range(0, 2); bd = $urandom_range(0, 2);
            model(we, addr, wd, rd, sz, uns, rsp, e_bad, e_err, e_rdata, e_wdata, e_strb);
            if (e_bad) e_lat = 1;
            else if (we) e_lat = 3 + ((awd > wdd) ? awd : wdd) + bd;
            else e_lat = 3 + ard + rdd;
            run_txn(we, addr, wd, 2'(sz), uns, rd, rsp, ard, rdd, awd, wdd, bd,
                    $urandom_range(0, 2), o);
            check_txn($sformatf("rnd%0d", n), o, we, addr, e_bad, e_err, e_rdata, e_wdata, e_strb, e_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
